// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready channel bundle for one elastic pipeline stage: upstream offer,
// downstream accept, squash control and the occupancy status.
`timescale 1ns/1ps
interface pipeline_skid_stage_if #(
  parameter int DATA_WIDTH = 128,
  parameter int TAG_WIDTH  = 3
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [1:0]            occupancy;

  // Environment side: offers entries, accepts results, issues flushes.
  modport master (
    output flush, in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, occupancy
  );

  // Stage side.
  modport slave (
    input  flush, in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, occupancy
  );
endinterface

// File: rtl/pipeline_skid_stage.sv
// Elastic inter-stage register: a main entry that drives the outputs plus a
// skid entry that absorbs the one extra beat arriving while in_ready is still
// high from the previous cycle. in_ready is derived only from registers, so
// backpressure moves back one stage per cycle with no combinational ready path.
`timescale 1ns/1ps
module pipeline_skid_stage #(
  parameter int DATA_WIDTH  = 128,
  parameter int TAG_WIDTH   = 3,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_skid_stage_if.slave  bus
);

  // {s_valid, m_valid}; 2'b10 is unreachable and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  localparam bit BZ = (BUBBLE_ZERO != 0);

  state_t                state_q, state_d;
  logic                  rst_q;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic [TAG_WIDTH-1:0]  m_tag_q, m_tag_d;
  logic [TAG_WIDTH-1:0]  s_tag_q, s_tag_d;
  logic                  m_valid, s_valid;
  logic                  in_ready;
  logic                  in_fire, out_fire;

  assign m_valid  = state_q[0];
  assign s_valid  = state_q[1];
  assign in_ready = !s_valid && !rst_q;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = m_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data_q;
  assign bus.out_tag   = m_tag_q;
  assign bus.occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  // Next-state and entry-movement logic; flush empties everything, dropping a
  // simultaneous incoming entry (a simultaneous out_fire has already been seen).
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_tag_d  = m_tag_q;
    s_data_d = s_data_q;
    s_tag_d  = s_tag_q;
    if (bus.flush) begin
      state_d = EMPTY;
      if (BZ) begin
        m_data_d = '0;
        m_tag_d  = '0;
        s_data_d = '0;
        s_tag_d  = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d  = ONE;
            m_data_d = bus.in_data;
            m_tag_d  = bus.in_tag;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data_d = bus.in_data;
            m_tag_d  = bus.in_tag;
          end else if (in_fire) begin
            state_d  = FULL;
            s_data_d = bus.in_data;
            s_tag_d  = bus.in_tag;
          end else if (out_fire) begin
            state_d = EMPTY;
            if (BZ) begin
              m_data_d = '0;
              m_tag_d  = '0;
            end
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            m_tag_d  = s_tag_q;
            if (BZ) begin
              s_data_d = '0;
              s_tag_d  = '0;
            end
          end
        end
        default: begin
          state_d  = EMPTY;
          m_data_d = '0;
          m_tag_d  = '0;
          s_data_d = '0;
          s_tag_d  = '0;
        end
      endcase
    end
  end

  // State and entry registers; reset wins over flush and any handshake.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_tag_q  <= '0;
      s_data_q <= '0;
      s_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_tag_q  <= m_tag_d;
      s_data_q <= s_data_d;
      s_tag_q  <= s_tag_d;
    end
  end

endmodule

// File: doc/pipeline_skid_stage.md
# pipeline_skid_stage

Parametrised elastic pipeline-stage register that replaces the fixed-field stall/flush inter-stage latches with a valid/ready handshake and a two-entry skid buffer. It carries an opaque payload plus an active-list tag between any two pipeline stages (fetch→decode, decode→execute, execute→memory). Backpressure propagates one stage per cycle through a registered `in_ready`, with no combinational ready path. A synchronous flush squashes all held entries.

## Interface
Parameters:
- `DATA_WIDTH`, 128: payload width in bits (concatenated stage fields), ≥1.
- `TAG_WIDTH`, 3: active-list index width carried beside the payload, ≥1.
- `BUBBLE_ZERO`, 1: 1 = payload and tag registers are cleared whenever their entry is emptied or flushed; 0 = payload registers are left stale, and only the valid bits clear.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all entries at the next edge.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  stage can accept; driven from a register.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `in_tag`  in  TAG_WIDTH  upstream active-list index.
- `out_valid`  out  1  main entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  main entry payload.
- `out_tag`  out  TAG_WIDTH  main entry tag.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Storage: main register (`m_valid`, data, tag) and skid register (`s_valid`, data, tag). Outputs come straight from main.
- Handshake signals:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - `in_ready = !s_valid & !rst_q`, where `rst_q` is a register set by `rst`.
- State is encoded by {`s_valid`, `m_valid`}:
  - EMPTY: 00.
  - ONE: 01.
  - FULL: 11.
  - 10 is illegal and must never occur.
- Transitions when `flush` = 0:
  - EMPTY: `in_fire` → ONE, main ← in.
  - ONE: `in_fire & out_fire` → ONE, main ← in.
  - ONE: `in_fire & !out_fire` → FULL, skid ← in.
  - ONE: `!in_fire & out_fire` → EMPTY.
  - ONE: neither → hold.
  - FULL: `in_fire` is impossible. `out_fire` → ONE, main ← skid, skid cleared. Otherwise hold.
- Ordering: strict FIFO; entries leave in acceptance order.
- Stability: while `out_valid & !out_ready`, `out_data`/`out_tag` do not change.
- `flush` = 1:
  - Next state is EMPTY, regardless of the handshakes.
  - An entry presented with `in_fire` in the same cycle is dropped.
  - An `out_fire` in the same cycle still counts as consumed downstream.
- `BUBBLE_ZERO` = 1: main and skid data/tag go to 0 when that entry becomes empty or is flushed.
- `occupancy = m_valid + s_valid`.

## Timing
- Reset:
  - While `rst` is sampled high: at the edge, `out_valid` = 0, `out_data` = 0, `out_tag` = 0, `occupancy` = 0, `s_valid` = 0, `rst_q` = 1.
  - `in_ready` is 0 for the first cycle after `rst` deasserts, then 1.
  - Reset overrides `flush` and all handshakes, including mid-transfer.
- Latency: an accepted entry is visible on `out_*` the cycle after `in_fire` when the stage was EMPTY, or ONE with a simultaneous `out_fire`.
- Throughput: 1 entry/cycle sustained with `out_ready` held high.
- Backpressure:
  - `out_ready` low for k ≥ 1 cycles → `in_ready` drops one cycle after the skid fills.
  - One extra entry is absorbed; none is lost.
- `in_ready` reasserts the cycle after the `out_fire` that drains FULL → ONE.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.

## Test plan
- Reset mid-traffic: stream tags 1,2 with `out_ready` = 0, assert `rst` one cycle → next cycle `out_valid` = 0, `occupancy` = 0, `out_data` = 0; `in_ready` = 0 one cycle, then 1.
- Streaming: `out_ready` = 1, send data 0x10..0x17 on consecutive cycles → identical sequence out, each one cycle later; `in_ready` constantly 1.
- Skid fill: send A (tag 1), B (tag 2), C with `out_ready` = 0 → `occupancy` 1 then 2; `in_ready` = 0 after B, so C is not accepted. Raise `out_ready` → A, B, then C out in order; no duplicates.
- Flush priority: in FULL (A, B), assert `flush` with `in_valid` = 1 (D) and `out_ready` = 1 → next cycle `occupancy` = 0, `out_valid` = 0. D is never output; A is counted as consumed.
- Stability: hold `out_ready` = 0 for 5 cycles with `out_valid` = 1 → `out_data`/`out_tag` are constant every cycle while `in_valid` toggles.
- `BUBBLE_ZERO` = 0 build: drain to EMPTY → `out_valid` = 0, `out_data` retains the last value; FIFO order identical to the = 1 build.
